// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: FSM encoding, ROM region decode constant and default bus widths.
package memory_arbiter_pkg;
    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam logic [1:0] ROM_REGION = 2'b00;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    function automatic logic is_rom(input logic [1:0] region);
        return region == ROM_REGION;
    endfunction
endpackage

// File: rtl/memory_decoder.sv
// memory_decoder: turns the active access into a ROM or RAM select plus the write strobe.
module memory_decoder
    import memory_arbiter_pkg::*;
(
    input  logic       en_i,
    input  logic       write_i,
    input  logic [1:0] region_i,
    output logic       ram_cs_o,
    output logic       rom_cs_o,
    output logic       we_o
);
    logic rom;
    always_comb begin
        rom      = is_rom(region_i);
        ram_cs_o = en_i && !rom;
        // a write aimed at ROM selects nothing, but the requester is still acked
        rom_cs_o = en_i && rom && !write_i;
        we_o     = en_i && write_i && !rom;
    end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: CPU/VDP shared-memory arbiter, VDP priority, one access per 3 cycles.
// Define MEMORY_ARBITER_STARVE_GUARD_EN to let a waiting CPU win after STARVE_LIMIT VDP grants.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpuReq,
    input  logic                  cpuWrite,
    input  logic [ADDR_WIDTH-1:0] cpuAddress,
    input  logic [DATA_WIDTH-1:0] cpuDataIn,
    output logic                  cpuAck,
    output logic [DATA_WIDTH-1:0] cpuDataOut,
    input  logic                  vdpReq,
    input  logic [ADDR_WIDTH-1:0] vdpAddress,
    output logic                  vdpAck,
    output logic [DATA_WIDTH-1:0] vdpDataOut,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memDataOut,
    output logic                  memWriteEnabled,
    output logic                  ramChipSelect,
    output logic                  romChipSelect,
    input  logic [DATA_WIDTH-1:0] memDataIn
);
    state_e                state_q, state_d;
    logic                  cpu_win_q, cpu_win_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
    logic [DATA_WIDTH-1:0] vdp_data_q, vdp_data_d;
    logic                  arb, grant_cpu, starved, done;

    if (STARVE_LIMIT < 1) begin : g_limit_chk
        $error("memory_arbiter: STARVE_LIMIT must be at least 1");
    end

    always_comb begin
        arb        = state_q == IDLE && (cpuReq || vdpReq);
        grant_cpu  = cpuReq && (!vdpReq || starved);
        done       = state_q == DONE;
        state_d    = state_q == ACCESS ? DONE : (arb ? ACCESS : IDLE);
        cpu_win_d  = arb ? grant_cpu : cpu_win_q;
        we_d       = arb ? grant_cpu && cpuWrite : we_q;
        addr_d     = arb ? (grant_cpu ? cpuAddress : vdpAddress) : addr_q;
        wdata_d    = arb ? (grant_cpu ? cpuDataIn : '0) : wdata_q;
        // synchronous memory: read data is only valid during DONE, so it is forwarded then and held after
        cpu_data_d = done && cpu_win_q ? memDataIn : cpu_data_q;
        vdp_data_d = done && !cpu_win_q ? memDataIn : vdp_data_q;
        cpuAck     = done && cpu_win_q;
        vdpAck     = done && !cpu_win_q;
        cpuDataOut = cpu_data_d;
        vdpDataOut = vdp_data_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cpu_win_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_data_q <= '0;
            vdp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cpu_win_q  <= cpu_win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_data_q <= cpu_data_d;
            vdp_data_q <= vdp_data_d;
        end
    end

`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    logic [SW-1:0] starve_q, starve_d;
    assign starved = starve_q >= SW'(STARVE_LIMIT);
    // once starved, any CPU request wins, so the counter never climbs past the limit
    always_comb starve_d = (!cpuReq || (arb && grant_cpu)) ? '0 : (arb ? starve_q + SW'(1) : starve_q);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_q <= '0;
        else starve_q <= starve_d;
    end
`else
    assign starved = 1'b0;
`endif

    assign memAddress = addr_q;
    assign memDataOut = wdata_q;

    memory_decoder u_dec (
        .en_i     (state_q == ACCESS),
        .write_i  (we_q),
        .region_i (addr_q[ADDR_WIDTH-1 -: 2]),
        .ram_cs_o (ramChipSelect),
        .rom_cs_o (romChipSelect),
        .we_o     (memWriteEnabled)
    );
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed latency/decode/reset checks plus random traffic against a transaction-level model.
module tb_memory_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LIMIT = 4;
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cpuReq, cpuWrite, vdpReq;
    logic [AW-1:0] cpuAddress, vdpAddress;
    logic [DW-1:0] cpuDataIn, memDataIn;
    logic          cpuAck, vdpAck, memWriteEnabled, ramChipSelect, romChipSelect;
    logic [DW-1:0] cpuDataOut, vdpDataOut, memDataOut;
    logic [AW-1:0] memAddress;
    int            total = 0;
    int            bad = 0;
    bit            chk_on = 1'b0;

    always #5 clk = ~clk;

    memory_arbiter dut (
        .clk(clk), .reset(rst),
        .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress), .cpuDataIn(cpuDataIn),
        .cpuAck(cpuAck), .cpuDataOut(cpuDataOut),
        .vdpReq(vdpReq), .vdpAddress(vdpAddress), .vdpAck(vdpAck), .vdpDataOut(vdpDataOut),
        .memAddress(memAddress), .memDataOut(memDataOut), .memWriteEnabled(memWriteEnabled),
        .ramChipSelect(ramChipSelect), .romChipSelect(romChipSelect), .memDataIn(memDataIn)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a grant occupies three slots (strobe, ack, gap-free return to idle); phase counts them.
    int            m_phase, m_starve;
    logic          m_cpu, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_cd, m_vd;
    logic          m_arb, m_pick_cpu, e_acc, e_dn, e_rom;
    assign m_arb      = m_phase == 0 && (cpuReq || vdpReq);
    assign m_pick_cpu = cpuReq && (!vdpReq || (GUARD && m_starve >= LIMIT));
    assign e_acc      = m_phase == 1;
    assign e_dn       = m_phase == 2;
    assign e_rom      = m_addr[AW-1 -: 2] == 2'b00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_starve <= 0; m_cpu <= 1'b0; m_we <= 1'b0;
            m_addr <= '0; m_wd <= '0; m_cd <= '0; m_vd <= '0;
        end else begin
            m_phase <= (m_phase == 0 && !m_arb) ? 0 : (m_phase + 1) % 3;
            if (m_arb) begin
                m_cpu  <= m_pick_cpu;
                m_addr <= m_pick_cpu ? cpuAddress : vdpAddress;
                m_wd   <= m_pick_cpu ? cpuDataIn : '0;
                m_we   <= m_pick_cpu && cpuWrite;
            end
            if (m_phase == 2 && m_cpu) m_cd <= memDataIn;
            if (m_phase == 2 && !m_cpu) m_vd <= memDataIn;
            m_starve <= (!cpuReq || (m_arb && m_pick_cpu)) ? 0 : (m_arb ? m_starve + 1 : m_starve);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("ramChipSelect", 32'(ramChipSelect), 32'(e_acc && !e_rom));
            cmp("romChipSelect", 32'(romChipSelect), 32'(e_acc && e_rom && !m_we));
            cmp("memWriteEnabled", 32'(memWriteEnabled), 32'(e_acc && m_we && !e_rom));
            cmp("memAddress", 32'(memAddress), 32'(m_addr));
            cmp("memDataOut", 32'(memDataOut), 32'(m_wd));
            cmp("cpuAck", 32'(cpuAck), 32'(e_dn && m_cpu));
            cmp("vdpAck", 32'(vdpAck), 32'(e_dn && !m_cpu));
            cmp("cpuDataOut", 32'(cpuDataOut), 32'((e_dn && m_cpu) ? memDataIn : m_cd));
            cmp("vdpDataOut", 32'(vdpDataOut), 32'((e_dn && !m_cpu) ? memDataIn : m_vd));
            cmp("ack_exclusive", 32'(cpuAck && vdpAck), 32'(0));
        end
    end

    initial begin
        logic ca, va;
        int   nv, nc;
        bit   cseen;
        rst = 1'b0; cpuReq = 1'b0; cpuWrite = 1'b0; vdpReq = 1'b0;
        cpuAddress = '0; vdpAddress = '0; cpuDataIn = '0; memDataIn = '0;
        #1 rst = 1'b1;
        chk_on = 1'b1;
        #2;
        cmp("rst_acks", 32'({cpuAck, vdpAck}), 32'(0));
        cmp("rst_strobes", 32'({ramChipSelect, romChipSelect, memWriteEnabled}), 32'(0));
        cmp("rst_bus", 32'({memAddress, memDataOut}), 32'(0));
        cmp("rst_data", 32'({cpuDataOut, vdpDataOut}), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // CPU read from RAM
        cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = 16'h8000; memDataIn = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        cmp("r030_ramcs", 32'(ramChipSelect), 32'(1));
        cmp("r030_romcs", 32'(romChipSelect), 32'(0));
        cmp("r030_addr", 32'(memAddress), 32'h8000);
        @(negedge clk);
        cmp("r030_ack", 32'(cpuAck), 32'(1));
        cmp("r030_data", 32'(cpuDataOut), 32'h5A);
        @(posedge clk);
        #1;

        // CPU write into ROM range
        cpuWrite = 1'b1; cpuAddress = 16'h0010; cpuDataIn = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        cmp("r031_cs", 32'({ramChipSelect, romChipSelect}), 32'(0));
        cmp("r031_we", 32'(memWriteEnabled), 32'(0));
        cmp("r031_wdata", 32'(memDataOut), 32'hFF);
        @(negedge clk);
        cmp("r031_ack", 32'(cpuAck), 32'(1));
        @(posedge clk);
        #1 cpuReq = 1'b0;

        // contested arbitration: VDP first, CPU three cycles later
        cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = 16'h4000;
        vdpReq = 1'b1; vdpAddress = 16'h1234; memDataIn = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        cmp("r032_vdp_romcs", 32'(romChipSelect), 32'(1));
        cmp("r032_vdp_addr", 32'(memAddress), 32'h1234);
        cmp("r032_vdp_wdata", 32'(memDataOut), 32'(0));
        @(negedge clk);
        cmp("r032_vdp_ack", 32'({vdpAck, cpuAck}), 32'b10);
        cmp("r032_vdp_data", 32'(vdpDataOut), 32'hC3);
        @(posedge clk);
        #1 vdpReq = 1'b0; memDataIn = 8'h3C;
        @(negedge clk);
        cmp("r032_gap", 32'(cpuAck), 32'(0));
        @(negedge clk);
        cmp("r032_cpu_ramcs", 32'(ramChipSelect), 32'(1));
        @(negedge clk);
        cmp("r032_cpu_ack", 32'(cpuAck), 32'(1));
        cmp("r032_cpu_data", 32'(cpuDataOut), 32'h3C);
        cmp("r032_vdp_hold", 32'(vdpDataOut), 32'hC3);
        @(posedge clk);
        #1 cpuReq = 1'b0;

        // VDP hogging the bus while the CPU waits
        cpuReq = 1'b1; cpuAddress = 16'hA000; vdpReq = 1'b1; vdpAddress = 16'h2000;
        nv = 0; cseen = 1'b0;
        for (int i = 0; i < 30 && !cseen; i++) begin
            @(negedge clk);
            if (cpuAck) cseen = 1'b1;
            else if (vdpAck) nv++;
        end
        cmp("r033_cpu_served", 32'(cseen), 32'(GUARD));
        cmp("r033_vdp_grants", 32'(nv), GUARD ? 32'(4) : 32'(10));
        @(posedge clk);
        #1 cpuReq = 1'b0; vdpReq = 1'b0;

        // reset in the middle of a CPU write
        cpuReq = 1'b1; cpuWrite = 1'b1; cpuAddress = 16'hC000; cpuDataIn = 8'h77;
        @(posedge clk);
        #1;
        cmp("r034_we_before", 32'(memWriteEnabled), 32'(1));
        rst = 1'b1; cpuReq = 1'b0;
        #1;
        cmp("r034_we_drop", 32'(memWriteEnabled), 32'(0));
        cmp("r034_cs_drop", 32'(ramChipSelect), 32'(0));
        cmp("r034_bus_clr", 32'({memAddress, memDataOut}), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        nc = 0;
        repeat (6) begin
            @(negedge clk);
            nc += int'(cpuAck);
        end
        cmp("r034_no_ack", 32'(nc), 32'(0));

        // random traffic obeying the hold-until-ack protocol
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ca = cpuAck; va = vdpAck;
            @(posedge clk);
            #1;
            memDataIn = DW'($urandom);
            if (!cpuReq || ca) begin
                cpuReq = $urandom_range(0, 2) != 0;
                cpuWrite = 1'($urandom);
                cpuAddress = AW'($urandom);
                cpuDataIn = DW'($urandom);
            end
            if (!vdpReq || va) begin
                vdpReq = $urandom_range(0, 3) != 0;
                vdpAddress = AW'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; cpuReq = 1'b0; vdpReq = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
